ps2_cmd_scheduler: RTL and testbench

- Sits between the PS/2 keyboard scanner (ps2k_clk domain, outputs make-code byte plus state flag) and the scoreboard core (clk domain).
- Synchronises the scanner outputs, turns each new key press into a scoreboard command, and enforces scoring hold-off and pause lockout.
- Buffers accepted commands in a small FIFO and hands them to the scoreboard over a valid/ready handshake.

---
 rtl/ps2_cmd_scheduler_if.sv | 15 +
 rtl/ps2_cmd_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ps2_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_cmd_scheduler_if.sv
// ps2_cmd_scheduler_if
//   Command handshake between the PS/2 command scheduler and the scoreboard core.
//   cmd_valid : head of the command FIFO holds a command
//   cmd_code  : command at the FIFO head (0 when empty)
//   cmd_ready : scoreboard takes cmd_code this cycle
//   master    : scheduler side (drives valid/code)
//   slave     : scoreboard side (drives ready)
interface ps2_cmd_scheduler_if;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/ps2_cmd_scheduler.sv
// ps2_cmd_scheduler
//   Brings the PS/2 scanner outputs into the clk domain, turns each new key
//   press into a scoreboard command, applies scoring hold-off and pause
//   lockout, and queues accepted commands in a first-word-fall-through FIFO.
//
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   ps2_byte   : scanner make code (asynchronous to clk)
//   ps2_state  : scanner key-down flag (asynchronous to clk)
//   cmd        : command handshake (valid/code out, ready in)
//   paused     : game paused flag
//   drop_count : saturating count of dropped commands
//   fifo_level : current FIFO occupancy
module ps2_cmd_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    ps2_byte,
    input  logic                          ps2_state,
    ps2_cmd_scheduler_if.master           cmd,
    output logic                          paused,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLDOFF_L = HW'(HOLDOFF);

    localparam logic [2:0] CMD_NONE     = 3'd0;
    localparam logic [2:0] CMD_HOME_P2  = 3'd1;
    localparam logic [2:0] CMD_HOME_P3  = 3'd2;
    localparam logic [2:0] CMD_GUEST_P2 = 3'd3;
    localparam logic [2:0] CMD_GUEST_P3 = 3'd4;
    localparam logic [2:0] CMD_PAUSE    = 3'd5;

    // ------------------------------------------------------------------
    // Synchronisers. The scanner holds the byte stable while state is high,
    // so the byte bus only needs the same flop chain as the flag.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] state_sync;
    logic [7:0]             byte_sync [SYNC_STAGES];
    logic                   prev_state;
    logic                   sync_state;
    logic [7:0]             sync_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_sync <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                byte_sync[i] <= '0;
            end
            prev_state <= 1'b0;
        end else begin
            state_sync <= {state_sync[SYNC_STAGES-2:0], ps2_state};
            byte_sync[0] <= ps2_byte;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                byte_sync[i] <= byte_sync[i-1];
            end
            prev_state <= state_sync[SYNC_STAGES-1];
        end
    end

    assign sync_state = state_sync[SYNC_STAGES-1];
    assign sync_byte  = byte_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Event detection and decode
    // ------------------------------------------------------------------
    logic       key_event;
    logic [2:0] code;

    assign key_event = sync_state & ~prev_state;

    always_comb begin
        code = CMD_NONE;
        if (key_event) begin
            case (sync_byte)
                8'h1C:   code = CMD_HOME_P2;
                8'h1B:   code = CMD_HOME_P3;
                8'h42:   code = CMD_GUEST_P2;
                8'h4B:   code = CMD_GUEST_P3;
                8'h29:   code = CMD_PAUSE;
                default: code = CMD_NONE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Acceptance
    // ------------------------------------------------------------------
    logic [HW-1:0] holdoff_cnt;
    logic          pop;
    logic          room;
    logic          is_pause;
    logic          is_score;
    logic          push;
    logic          drop;

    assign pop      = cmd.cmd_valid & cmd.cmd_ready;
    // A full FIFO popping in the same cycle frees the slot the push needs.
    assign room     = (fifo_level < DEPTH_L) | pop;
    assign is_pause = (code == CMD_PAUSE);
    assign is_score = (code != CMD_NONE) & ~is_pause;
    assign push     = room & (is_pause | (is_score & ~paused & (holdoff_cnt == '0)));
    assign drop     = (code != CMD_NONE) & ~push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdoff_cnt <= '0;
        end else if (push && is_score) begin
            holdoff_cnt <= HOLDOFF_L;
        end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paused <= 1'b0;
        end else if (push && is_pause) begin
            paused <= ~paused;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign cmd.cmd_valid = (fifo_level != '0);
    assign cmd.cmd_code  = cmd.cmd_valid ? mem[rd_ptr] : CMD_NONE;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// tb_ps2_cmd_scheduler
//   Directed scenarios followed by random key presses with random cmd_ready,
//   compared every cycle against a queue-based reference model.
module tb_ps2_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HOLD  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_state = 1'b0;
    logic       paused;
    logic [7:0] drop_count;
    logic [2:0] fifo_level;

    ps2_cmd_scheduler_if cmd_if ();

    ps2_cmd_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .HOLDOFF     (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_byte   (ps2_byte),
        .ps2_state  (ps2_state),
        .cmd        (cmd_if.master),
        .paused     (paused),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of commands, edge-indexed input history,
    // hold-off expressed as distance in edges from the last scoring push.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       st;
        logic [7:0] by;
    } samp_t;

    samp_t       hist [$];
    int unsigned mq [$];
    bit          m_paused;
    int          m_drops;
    longint      edge_n;
    longint      last_score;
    bit          score_seen;

    function automatic int unsigned decode(input logic [7:0] b);
        case (b)
            8'h1C:   return 1;
            8'h1B:   return 2;
            8'h42:   return 3;
            8'h4B:   return 4;
            8'h29:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back('0);
        mq.delete();
        m_paused   = 1'b0;
        m_drops    = 0;
        edge_n     = 0;
        score_seen = 1'b0;
        last_score = 0;
    endtask

    always @(posedge clk or negedge reset) begin : model_step
        samp_t       now_s;
        samp_t       old_s;
        int unsigned c;
        bit          ok;
        if (!reset) begin
            model_clear();
        end else begin
            edge_n++;
            now_s = hist[hist.size()-SYNC];
            old_s = hist[hist.size()-SYNC-1];
            c = (now_s.st && !old_s.st) ? decode(now_s.by) : 0;
            if (mq.size() != 0 && cmd_if.cmd_ready) void'(mq.pop_front());
            if (c != 0) begin
                ok = (mq.size() < DEPTH) &&
                     (c == 5 || (!m_paused && (!score_seen || (edge_n - last_score) > HOLD)));
                if (ok) begin
                    mq.push_back(c);
                    if (c == 5) begin
                        m_paused = !m_paused;
                    end else begin
                        last_score = edge_n;
                        score_seen = 1'b1;
                    end
                end else if (m_drops < 255) begin
                    m_drops++;
                end
            end
            hist.push_back('{st: ps2_state, by: ps2_byte});
            void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        check("m_valid",  cmd_if.cmd_valid, (mq.size() != 0) ? 1 : 0);
        check("m_code",   cmd_if.cmd_code,  (mq.size() != 0) ? mq[0] : 0);
        check("m_paused", paused,           m_paused);
        check("m_drops",  drop_count,       m_drops);
        check("m_level",  fifo_level,       mq.size());
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit rnd_ready = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) cmd_if.cmd_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press(input logic [7:0] b, input int hold, input int gap);
        ps2_byte  = b;
        ps2_state = 1'b1;
        tick(hold);
        ps2_state = 1'b0;
        tick(gap);
    endtask

    logic [7:0] picks [8];

    initial begin
        picks = '{8'h1C, 8'h1B, 8'h42, 8'h4B, 8'h29, 8'h22, 8'h00, 8'hF0};
        model_clear();
        cmd_if.cmd_ready = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);

        // reset state
        check("rst_valid", cmd_if.cmd_valid, 0);
        check("rst_code",  cmd_if.cmd_code,  0);
        check("rst_pause", paused,           0);
        check("rst_drops", drop_count,       0);
        check("rst_level", fifo_level,       0);

        // latency: valid three edges after the state rise, for one cycle
        cmd_if.cmd_ready = 1'b1;
        ps2_byte  = 8'h1C;
        ps2_state = 1'b1;
        tick(1); check("lat_e1", cmd_if.cmd_valid, 0);
        tick(1); check("lat_e2", cmd_if.cmd_valid, 0);
        tick(1); check("lat_e3", cmd_if.cmd_valid, 1);
                 check("lat_code", cmd_if.cmd_code, 1);
        tick(1); check("lat_e4", cmd_if.cmd_valid, 0);
        tick(16);
        ps2_state = 1'b0;
        tick(5);
        check("lat_drops", drop_count, 0);

        // hold-off
        press(8'h1C, 2, 3);
        press(8'h4B, 2, 20);
        check("ho_drop", drop_count, 1);
        press(8'h4B, 2, 20);
        check("ho_after", drop_count, 1);

        // pause lockout
        press(8'h29, 2, 15); check("pz_on",    paused, 1);
        press(8'h42, 2, 15); check("pz_drop",  drop_count, 2);
        press(8'h29, 2, 15); check("pz_off",   paused, 0);
        press(8'h42, 2, 15); check("pz_score", drop_count, 2);

        // fill to full, fifth dropped
        cmd_if.cmd_ready = 1'b0;
        press(8'h1C, 2, 12);
        press(8'h29, 2, 12);
        press(8'h29, 2, 12);
        press(8'h1B, 2, 12);
        press(8'h42, 2, 12);
        check("full_level", fifo_level, 4);
        check("full_drops", drop_count, 3);

        // drain in push order
        cmd_if.cmd_ready = 1'b1;
        check("drain0", cmd_if.cmd_code, 1);
        tick(1); check("drain1", cmd_if.cmd_code, 5);
        tick(1); check("drain2", cmd_if.cmd_code, 5);
        tick(1); check("drain3", cmd_if.cmd_code, 2);
        tick(1); check("drain_empty", cmd_if.cmd_valid, 0);

        // full FIFO, push and pop on the same edge
        cmd_if.cmd_ready = 1'b0;
        press(8'h29, 2, 12);
        press(8'h29, 2, 12);
        press(8'h1C, 2, 12);
        press(8'h29, 2, 12);
        check("sim_pre_level", fifo_level, 4);
        ps2_byte  = 8'h29;
        ps2_state = 1'b1;
        tick(2);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        check("sim_level", fifo_level, 4);
        check("sim_drops", drop_count, 3);
        check("sim_pause", paused, 0);
        ps2_state = 1'b0;
        tick(10);

        // reset mid-operation
        cmd_if.cmd_ready = 1'b0;
        press(8'h29, 2, 12);
        press(8'h29, 2, 12);
        press(8'h29, 2, 12);
        check("mid_level", fifo_level, 3);
        check("mid_pause", paused, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", cmd_if.cmd_valid, 0);
        check("mid_rst_code",  cmd_if.cmd_code,  0);
        check("mid_rst_pause", paused,           0);
        check("mid_rst_drops", drop_count,       0);
        check("mid_rst_level", fifo_level,       0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick(2);

        // unrecognised byte
        press(8'h22, 2, 10);
        check("unk_level", fifo_level, 0);
        check("unk_drops", drop_count, 0);

        // random traffic
        rnd_ready = 1'b1;
        repeat (200) begin
            press(picks[$urandom_range(0, 7)], int'($urandom_range(1, 4)), int'($urandom_range(0, 15)));
        end
        rnd_ready = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        tick(10);
        check("end_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
